// File: rtl/can_filter_ctrl.sv
// can_filter_ctrl: sequential CAN acceptance filter, one code/mask entry scanned per clock.
// Optional per-entry saturating hit counters when CAN_FILTER_HITCNT_EN is defined.
module can_filter_ctrl #(
  parameter int NUM_FILTERS = 4,
  parameter int IDX_W = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [28:0]      cfg_code,
  input  logic [28:0]      cfg_mask,
  input  logic             cfg_enable,
  output logic             cfg_err,
  input  logic             frame_valid,
  output logic             frame_ready,
  input  logic             ide,
  input  logic [10:0]      id_std,
  input  logic [17:0]      id_ext,
  output logic             result_valid,
  output logic             accept_frame,
  output logic [IDX_W-1:0] match_idx,
  output logic [15:0]      hit_count
);
  typedef enum logic {IDLE, SCAN} state_t;
  state_t state_q, state_d;
  logic [IDX_W-1:0] scan_q, scan_d, match_idx_q, match_idx_d;
  logic ide_q, ide_d, result_valid_q, result_valid_d, accept_q, accept_d, cfg_err_q, cfg_err_d;
  logic [28:0] id_q, id_d, cmp_mask;
  logic [28:0] code_q [NUM_FILTERS];
  logic [28:0] code_d [NUM_FILTERS];
  logic [28:0] mask_q [NUM_FILTERS];
  logic [28:0] mask_d [NUM_FILTERS];
  logic [NUM_FILTERS-1:0] en_q, en_d;
  logic [2**IDX_W-1:0] idx_ok;
  logic cfg_wr, hit, last;
  for (genvar i = 0; i < 2**IDX_W; i++) begin : g_ok
    assign idx_ok[i] = (i < NUM_FILTERS);
  end
  assign frame_ready  = (state_q == IDLE);
  assign result_valid = result_valid_q;
  assign accept_frame = accept_q;
  assign match_idx    = match_idx_q;
  assign cfg_err      = cfg_err_q;
  // Standard frames compare only the base-ID field of the entry.
  assign cmp_mask = ide_q ? mask_q[scan_q] : {mask_q[scan_q][28:18], 18'b0};
  assign hit  = en_q[scan_q] && (((id_q ^ code_q[scan_q]) & cmp_mask) == 29'b0);
  assign last = (scan_q == IDX_W'(NUM_FILTERS - 1));
  always_comb begin
    state_d        = state_q;
    scan_d         = scan_q;
    ide_d          = ide_q;
    id_d           = id_q;
    code_d         = code_q;
    mask_d         = mask_q;
    en_d           = en_q;
    result_valid_d = 1'b0;
    accept_d       = accept_q;
    match_idx_d    = match_idx_q;
    cfg_wr         = cfg_we && frame_ready && idx_ok[cfg_idx];
    cfg_err_d      = cfg_we && !cfg_wr;
    if (cfg_wr) begin
      code_d[cfg_idx] = cfg_code;
      mask_d[cfg_idx] = cfg_mask;
      en_d[cfg_idx]   = cfg_enable;
    end
    if (state_q == IDLE) begin
      if (frame_valid) begin
        state_d = SCAN;
        scan_d  = '0;
        ide_d   = ide;
        id_d    = {id_std, id_ext};
      end
    end else if (hit || last) begin
      state_d        = IDLE;
      result_valid_d = 1'b1;
      accept_d       = hit;
      match_idx_d    = hit ? scan_q : '0;
    end else begin
      scan_d = scan_q + 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      scan_q         <= '0;
      ide_q          <= 1'b0;
      id_q           <= '0;
      code_q         <= '{default: '0};
      mask_q         <= '{default: '0};
      en_q           <= '0;
      result_valid_q <= 1'b0;
      accept_q       <= 1'b0;
      match_idx_q    <= '0;
      cfg_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      scan_q         <= scan_d;
      ide_q          <= ide_d;
      id_q           <= id_d;
      code_q         <= code_d;
      mask_q         <= mask_d;
      en_q           <= en_d;
      result_valid_q <= result_valid_d;
      accept_q       <= accept_d;
      match_idx_q    <= match_idx_d;
      cfg_err_q      <= cfg_err_d;
    end
  end
`ifdef CAN_FILTER_HITCNT_EN
  logic [15:0] hit_q [NUM_FILTERS];
  logic [15:0] hit_d [NUM_FILTERS];
  always_comb begin
    hit_d = hit_q;
    if (cfg_wr) hit_d[cfg_idx] = '0;
    if (state_q == SCAN && hit && hit_q[scan_q] != 16'hFFFF) hit_d[scan_q] = hit_q[scan_q] + 1'b1;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) hit_q <= '{default: '0};
    else hit_q <= hit_d;
  end
  assign hit_count = idx_ok[cfg_idx] ? hit_q[cfg_idx] : 16'h0;
`else
  assign hit_count = 16'h0;
`endif
endmodule
